// File: rtl/ice40ultra_clk_manager.sv
// PLL-domain clock/reset manager: 2-flop lock sync, lock hold-off, staggered channel reset release, per-channel divided CE, lock-loss counter.
// All outputs registered; pll_lock loss reaches outputs 3 edges later. CLKMGR_SOFT_RESET_EN adds sw_rst_req resequencing from RUN.
module ice40ultra_clk_manager #(
    parameter int                       NUM_CH    = 3,
    parameter int                       DIV_W     = 8,
    parameter logic [NUM_CH*DIV_W-1:0]  CH_DIV    = {8'd5, 8'd2, 8'd1},
    parameter int                       LOCK_HOLD = 1024,
    parameter int                       STAGGER   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pll_lock,
`ifdef CLKMGR_SOFT_RESET_EN
    input  logic              sw_rst_req,
`endif
    output logic [NUM_CH-1:0] rst_n_out,
    output logic [NUM_CH-1:0] ce,
    output logic              ready,
    output logic [7:0]        lock_loss_cnt
);

    localparam int HW = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
    localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(LOCK_HOLD - 1);
    localparam logic [SW-1:0] STG_LAST  = SW'(STAGGER - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, RUN} state_t;

    state_t            state, state_nxt;
    logic              lock_meta, lock_s;
    logic [HW-1:0]     hold_cnt, hold_nxt;
    logic [SW-1:0]     stg_cnt, stg_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [NUM_CH-1:0] rst_nxt;
    logic              ready_nxt;
    logic [7:0]        loss_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_meta     <= 1'b0;
            lock_s        <= 1'b0;
            state         <= WAIT_LOCK;
            hold_cnt      <= '0;
            stg_cnt       <= '0;
            idx           <= '0;
            rst_n_out     <= '0;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            lock_meta     <= pll_lock;
            lock_s        <= lock_meta;
            state         <= state_nxt;
            hold_cnt      <= hold_nxt;
            stg_cnt       <= stg_nxt;
            idx           <= idx_nxt;
            rst_n_out     <= rst_nxt;
            ready         <= ready_nxt;
            lock_loss_cnt <= loss_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        stg_nxt   = stg_cnt;
        idx_nxt   = idx;
        rst_nxt   = rst_n_out;
        ready_nxt = ready;
        loss_nxt  = lock_loss_cnt;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = HOLD;
                    hold_nxt  = '0;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = RELEASE;
                    stg_nxt   = '0;
                    idx_nxt   = '0;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            RELEASE: begin
                // Last channel already out of reset: move to RUN one cycle after its release
                if (rst_n_out[NUM_CH-1]) begin
                    state_nxt = RUN;
                    ready_nxt = 1'b1;
                end else begin
                    if (stg_cnt == '0) begin
                        rst_nxt[idx] = 1'b1;
                        if (idx != IDX_LAST)
                            idx_nxt = idx + 1'b1;
                    end
                    stg_nxt = (stg_cnt == STG_LAST) ? '0 : stg_cnt + 1'b1;
                end
            end
            RUN: begin
                ready_nxt = 1'b1;
`ifdef CLKMGR_SOFT_RESET_EN
                if (sw_rst_req) begin
                    state_nxt = HOLD;
                    hold_nxt  = '0;
                    rst_nxt   = '0;
                    ready_nxt = 1'b0;
                end
`endif
            end
            default: state_nxt = WAIT_LOCK;
        endcase

        // Lock loss overrides everything, including a same-cycle soft reset request
        if (state != WAIT_LOCK && !lock_s) begin
            state_nxt = WAIT_LOCK;
            hold_nxt  = '0;
            stg_nxt   = '0;
            idx_nxt   = '0;
            rst_nxt   = '0;
            ready_nxt = 1'b0;
            if ((state == RELEASE || state == RUN) && lock_loss_cnt != 8'hFF)
                loss_nxt = lock_loss_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_div
        localparam logic [DIV_W-1:0] D   = CH_DIV[i*DIV_W +: DIV_W];
        localparam logic [DIV_W-1:0] DM1 = D - DIV_W'(1);
        localparam bit               ALWAYS_ON = (D <= DIV_W'(1));
        logic [DIV_W-1:0] div_cnt;

        always_ff @(posedge clk) begin
            if (!reset) begin
                div_cnt <= '0;
                ce[i]   <= 1'b0;
            end else begin
                if (rst_nxt[i] && rst_n_out[i])
                    div_cnt <= (div_cnt == DM1 || ALWAYS_ON) ? '0 : div_cnt + 1'b1;
                else
                    div_cnt <= '0;
                ce[i] <= rst_nxt[i] && (ALWAYS_ON || (rst_n_out[i] && div_cnt == DM1));
            end
        end
    end

endmodule

// File: tb/tb_ice40ultra_clk_manager.sv
// Randomized bench for ice40ultra_clk_manager against a time-since-lock reference model.
module tb_ice40ultra_clk_manager;

    localparam int NUM_CH    = 3;
    localparam int DIV_W     = 8;
    localparam int LOCK_HOLD = 16;
    localparam int STAGGER   = 4;
    localparam logic [NUM_CH*DIV_W-1:0] CH_DIV = {8'd5, 8'd2, 8'd1};
    localparam int READY_T   = LOCK_HOLD + 2 + (NUM_CH - 1) * STAGGER;
`ifdef CLKMGR_SOFT_RESET_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              pll_lock;
    logic              sw_rst_req;
    logic [NUM_CH-1:0] rst_n_out;
    logic [NUM_CH-1:0] ce;
    logic              ready;
    logic [7:0]        lock_loss_cnt;

    int dv [NUM_CH] = '{1, 2, 5};
    int n_chk = 0;
    int n_err = 0;

    // model: m_t counts edges since HOLD was entered
    bit m_valid = 1'b0;
    bit m_act   = 1'b0;
    int m_t     = 0;
    int m_loss  = 0;
    bit m_s1    = 1'b0;
    bit m_s2    = 1'b0;

    always #5 clk = ~clk;

    ice40ultra_clk_manager #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .CH_DIV(CH_DIV),
        .LOCK_HOLD(LOCK_HOLD), .STAGGER(STAGGER)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pll_lock(pll_lock),
`ifdef CLKMGR_SOFT_RESET_EN
        .sw_rst_req(sw_rst_req),
`endif
        .rst_n_out(rst_n_out),
        .ce(ce),
        .ready(ready),
        .lock_loss_cnt(lock_loss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int rel_t(input int i);
        return LOCK_HOLD + 1 + i * STAGGER;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_rst();
        logic [NUM_CH-1:0] r = '0;
        for (int i = 0; i < NUM_CH; i++)
            r[i] = m_act && (m_t >= rel_t(i));
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_ce();
        logic [NUM_CH-1:0] c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (dv[i] <= 1)
                c[i] = m_act && (m_t >= rel_t(i));
            else
                c[i] = m_act && (m_t >= rel_t(i) + dv[i]) && ((m_t - rel_t(i)) % dv[i] == 0);
        end
        return c;
    endfunction

    function automatic void model_step(input bit r, input bit l, input bit s);
        if (!r) begin
            m_valid = 1'b1;
            m_act   = 1'b0;
            m_t     = 0;
            m_loss  = 0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            return;
        end
        if (m_act && !m_s2) begin
            if (m_t >= LOCK_HOLD && m_loss < 255)
                m_loss++;
            m_act = 1'b0;
            m_t   = 0;
        end else if (!m_act && m_s2) begin
            m_act = 1'b1;
            m_t   = 0;
        end else if (SOFT && m_act && s && m_t >= READY_T) begin
            m_t = 0;
        end else if (m_act) begin
            m_t++;
        end
        m_s2 = m_s1;
        m_s1 = l;
    endfunction

    // compare outputs of the previous edge, then drive inputs for the next one
    task automatic cyc(input bit r, input bit l, input bit s);
        @(negedge clk);
        if (m_valid) begin
            chk("rst_n_out", 32'(rst_n_out), 32'(exp_rst()));
            chk("ce", 32'(ce), 32'(exp_ce()));
            chk("ready", 32'(ready), 32'(m_act && m_t >= READY_T));
            chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
        end
        reset      = r;
        pll_lock   = l;
        sw_rst_req = s;
        model_step(r, l, s);
    endtask

    initial begin
        bit l;
        reset      = 1'b0;
        pll_lock   = 1'b1;
        sw_rst_req = 1'b0;

        repeat (5) cyc(1'b0, 1'b1, 1'b0);
        repeat (60) cyc(1'b1, 1'b1, 1'b0);
        chk("nominal_ready", 32'(ready), 32'd1);

        cyc(1'b0, 1'b1, 1'b0);
        repeat ($urandom_range(10, 14)) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (18) cyc(1'b1, 1'b1, 1'b0);
        chk("glitch_no_release", 32'(rst_n_out), 32'd0);
        repeat (40) cyc(1'b1, 1'b1, 1'b0);
        chk("glitch_loss_cnt", 32'(lock_loss_cnt), 32'd0);

        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        chk("run_loss_cnt", 32'(lock_loss_cnt), 32'd1);
        chk("run_loss_rst", 32'(rst_n_out), 32'd0);
        repeat (40) cyc(1'b1, 1'b1, 1'b0);

        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(3, 5)) cyc(1'b1, 1'b0, 1'b0);
            repeat ($urandom_range(20, 30)) cyc(1'b1, 1'b1, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0);
        chk("saturate", 32'(lock_loss_cnt), 32'd255);

        repeat (10) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        repeat (40) cyc(1'b1, 1'b1, 1'b0);

        cyc(1'b0, 1'b1, 1'b0);
        l = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 29) == 0)
                l = ~l;
            cyc($urandom_range(0, 299) != 0, l, $urandom_range(0, 19) == 0);
        end
        cyc(1'b1, l, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
